// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - 8080-style LCD write-bus receiver decoding ILI9341 commands into RGB565 pixels
module lcd_bus_receiver #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lcd_db,
  input  logic       lcd_wr,
  input  logic       lcd_d_c,
  input  logic       lcd_rd,
  input  logic       lcd_reset,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [15:0] pix_rgb,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       bus_err
);

  localparam logic [9:0] XMAX = 10'(WIDTH - 1);
  localparam logic [9:0] YMAX = 10'(HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, PARAM, RAM_HI, RAM_LO, SKIP} state_t;

  logic       wr_s1, wr_s2, wr_prev, rst_s1, rst_s2;
  logic [7:0] db_s1, db_s2;
  logic       dc_s1, dc_s2, rd_s1, rd_s2;
  logic       soft_rst;

  logic       ev1_valid, ev2_valid, ev1_dc, ev2_dc, ev1_rd, ev2_rd;
  logic [7:0] ev1_db, ev2_db;

  state_t     state_q, state_n;
  logic [1:0] idx_q, idx_n, phi_q, phi_n;
  logic       row_q, row_n, seen_q, seen_n;
  logic [9:0] sc_q, sc_n, ec_q, ec_n, sp_q, sp_n, ep_q, ep_n;
  logic [9:0] x_q, x_n, y_q, y_n, pstart_q, pstart_n;
  logic [7:0] hi_q, hi_n;
  logic       pix_valid_n, cmd_valid_n, bus_err_n;
  logic [9:0] pix_x_n, pix_y_n;
  logic [15:0] pix_rgb_n;
  logic [7:0] cmd_code_n;

  // Two-flop synchronizers; strobe flops idle high so reset never fakes a rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_s1   <= 1'b1;
      wr_s2   <= 1'b1;
      wr_prev <= 1'b1;
      rst_s1  <= 1'b1;
      rst_s2  <= 1'b1;
    end else begin
      wr_s1   <= lcd_wr;
      wr_s2   <= wr_s1;
      wr_prev <= wr_s2;
      rst_s1  <= lcd_reset;
      rst_s2  <= rst_s1;
    end
    db_s1 <= lcd_db;
    db_s2 <= db_s1;
    dc_s1 <= lcd_d_c;
    dc_s2 <= dc_s1;
    rd_s1 <= lcd_rd;
    rd_s2 <= rd_s1;
  end

  assign soft_rst = reset | ~rst_s2;

  // Two-deep byte-event pipeline so decoded results land four clocks after the wr edge is first seen
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      ev1_valid <= 1'b0;
      ev2_valid <= 1'b0;
    end else begin
      ev1_valid <= wr_s2 & ~wr_prev;
      ev2_valid <= ev1_valid;
    end
    ev1_db <= db_s2;
    ev1_dc <= dc_s2;
    ev1_rd <= rd_s2;
    ev2_db <= ev1_db;
    ev2_dc <= ev1_dc;
    ev2_rd <= ev1_rd;
  end

  // Decoder state and registered outputs; panel reset restores the default window
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      phi_q     <= 2'd0;
      row_q     <= 1'b0;
      seen_q    <= 1'b0;
      sc_q      <= 10'd0;
      ec_q      <= XMAX;
      sp_q      <= 10'd0;
      ep_q      <= YMAX;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      pstart_q  <= 10'd0;
      hi_q      <= 8'd0;
      pix_valid <= 1'b0;
      pix_x     <= 10'd0;
      pix_y     <= 10'd0;
      pix_rgb   <= 16'd0;
      cmd_valid <= 1'b0;
      cmd_code  <= 8'd0;
      bus_err   <= 1'b0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      phi_q     <= phi_n;
      row_q     <= row_n;
      seen_q    <= seen_n;
      sc_q      <= sc_n;
      ec_q      <= ec_n;
      sp_q      <= sp_n;
      ep_q      <= ep_n;
      x_q       <= x_n;
      y_q       <= y_n;
      pstart_q  <= pstart_n;
      hi_q      <= hi_n;
      pix_valid <= pix_valid_n;
      pix_x     <= pix_x_n;
      pix_y     <= pix_y_n;
      pix_rgb   <= pix_rgb_n;
      cmd_valid <= cmd_valid_n;
      cmd_code  <= cmd_code_n;
      bus_err   <= bus_err_n;
    end
  end

  // Byte decode: commands abort any sequence; data bytes feed window params or pixel assembly
  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    phi_n       = phi_q;
    row_n       = row_q;
    seen_n      = seen_q;
    sc_n        = sc_q;
    ec_n        = ec_q;
    sp_n        = sp_q;
    ep_n        = ep_q;
    x_n         = x_q;
    y_n         = y_q;
    pstart_n    = pstart_q;
    hi_n        = hi_q;
    pix_valid_n = 1'b0;
    pix_x_n     = pix_x;
    pix_y_n     = pix_y;
    pix_rgb_n   = pix_rgb;
    cmd_valid_n = 1'b0;
    cmd_code_n  = cmd_code;
    bus_err_n   = 1'b0;
    if (ev2_valid) begin
      bus_err_n = ~ev2_rd;
      if (!ev2_dc) begin
        cmd_valid_n = 1'b1;
        cmd_code_n  = ev2_db;
        case (ev2_db)
          8'h2A, 8'h2B: begin
            state_n = PARAM;
            idx_n   = 2'd0;
            row_n   = ev2_db[0];
          end
          8'h2C: begin
            x_n     = sc_q;
            y_n     = sp_q;
            seen_n  = 1'b1;
            state_n = RAM_HI;
          end
          8'h3C: begin
            if (!seen_q) begin
              x_n = sc_q;
              y_n = sp_q;
            end
            state_n = RAM_HI;
          end
          8'h01: begin
            sc_n    = 10'd0;
            ec_n    = XMAX;
            sp_n    = 10'd0;
            ep_n    = YMAX;
            state_n = IDLE;
          end
          default: state_n = SKIP;
        endcase
      end else begin
        case (state_q)
          PARAM: begin
            idx_n = idx_q + 2'd1;
            case (idx_q)
              2'd0: pstart_n[9:8] = ev2_db[1:0];
              2'd1: pstart_n[7:0] = ev2_db;
              2'd2: phi_n = ev2_db[1:0];
              default: begin
                if (row_q) begin
                  sp_n = pstart_q;
                  ep_n = {phi_q, ev2_db};
                end else begin
                  sc_n = pstart_q;
                  ec_n = {phi_q, ev2_db};
                end
                state_n = IDLE;
              end
            endcase
          end
          RAM_HI: begin
            hi_n    = ev2_db;
            state_n = RAM_LO;
          end
          RAM_LO: begin
            pix_valid_n = 1'b1;
            pix_x_n     = x_q;
            pix_y_n     = y_q;
            pix_rgb_n   = {hi_q, ev2_db};
            state_n     = RAM_HI;
            if (x_q == ec_q || x_q == XMAX) begin
              x_n = sc_q;
              if (y_q == ep_q || y_q == YMAX) y_n = sp_q;
              else y_n = y_q + 10'd1;
            end else begin
              x_n = x_q + 10'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb/tb_lcd_bus_receiver.sv - directed scoreboard bench for lcd_bus_receiver
module tb_lcd_bus_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  lcd_db;
  logic        lcd_wr, lcd_d_c, lcd_rd, lcd_reset;
  logic        pix_valid, cmd_valid, bus_err;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] pix_rgb;
  logic [7:0]  cmd_code;

  lcd_bus_receiver #(.WIDTH(320), .HEIGHT(240)) dut (
    .clk(clk), .reset(reset), .lcd_db(lcd_db), .lcd_wr(lcd_wr), .lcd_d_c(lcd_d_c),
    .lcd_rd(lcd_rd), .lcd_reset(lcd_reset), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_rgb(pix_rgb), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails = 0;

  typedef struct {int due; logic [9:0] x; logic [9:0] y; logic [15:0] rgb;} pix_t;
  typedef struct {int due; logic [7:0] code;} cmd_t;
  pix_t pq[$];
  cmd_t cq[$];
  int   eq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every pulse must match the oldest expected entry, including its cycle
  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      check("pix_expected", 32'(pq.size() > 0), 32'd1);
      if (pq.size() > 0) begin
        pix_t p;
        p = pq.pop_front();
        check("pix_x", 32'(pix_x), 32'(p.x));
        check("pix_y", 32'(pix_y), 32'(p.y));
        check("pix_rgb", 32'(pix_rgb), 32'(p.rgb));
        check("pix_latency", 32'(cyc), 32'(p.due));
      end
    end
    if (cmd_valid === 1'b1) begin
      check("cmd_expected", 32'(cq.size() > 0), 32'd1);
      if (cq.size() > 0) begin
        cmd_t c;
        c = cq.pop_front();
        check("cmd_code", 32'(cmd_code), 32'(c.code));
        check("cmd_latency", 32'(cyc), 32'(c.due));
      end
    end
    if (bus_err === 1'b1) begin
      check("err_expected", 32'(eq.size() > 0), 32'd1);
      if (eq.size() > 0) begin
        int d;
        d = eq.pop_front();
        check("err_latency", 32'(cyc), 32'(d));
      end
    end
  end

  task automatic bus_write(input logic dc, input logic [7:0] b, input logic rd, input bit has_pix,
                           input logic [9:0] ex, input logic [9:0] ey, input logic [15:0] ergb);
    pix_t p;
    cmd_t c;
    @(negedge clk);
    lcd_db = b; lcd_d_c = dc; lcd_rd = rd; lcd_wr = 1'b0;
    repeat (3) @(negedge clk);
    lcd_wr = 1'b1;
    if (!dc) begin c.due = cyc + 5; c.code = b; cq.push_back(c); end
    if (!rd) eq.push_back(cyc + 5);
    if (has_pix) begin p.due = cyc + 5; p.x = ex; p.y = ey; p.rgb = ergb; pq.push_back(p); end
    repeat (2) @(negedge clk);
    lcd_rd = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    bus_write(1'b0, b, 1'b1, 1'b0, 10'd0, 10'd0, 16'd0);
  endtask

  task automatic send_data(input logic [7:0] b);
    bus_write(1'b1, b, 1'b1, 1'b0, 10'd0, 10'd0, 16'd0);
  endtask

  task automatic send_pix(input logic [9:0] x, input logic [9:0] y, input logic [15:0] rgb);
    bus_write(1'b1, rgb[15:8], 1'b1, 1'b0, 10'd0, 10'd0, 16'd0);
    bus_write(1'b1, rgb[7:0], 1'b1, 1'b1, x, y, rgb);
  endtask

  task automatic window(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    send_cmd(cmd);
    send_data(a); send_data(b); send_data(c); send_data(d);
  endtask

  initial begin
    reset = 1'b1; lcd_db = 8'h00; lcd_wr = 1'b1; lcd_d_c = 1'b1; lcd_rd = 1'b1; lcd_reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_pix_x", 32'(pix_x), 32'd0);
    check("rst_pix_y", 32'(pix_y), 32'd0);
    check("rst_pix_rgb", 32'(pix_rgb), 32'd0);
    check("rst_cmd_code", 32'(cmd_code), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 1: window 10..12 x 5..5, three primaries
    window(8'h2A, 8'h00, 8'h0A, 8'h00, 8'h0C);
    window(8'h2B, 8'h00, 8'h05, 8'h00, 8'h05);
    send_cmd(8'h2C);
    send_pix(10'd10, 10'd5, 16'hF800);
    send_pix(10'd11, 10'd5, 16'h07E0);
    send_pix(10'd12, 10'd5, 16'h001F);

    // 2: 2x2 window wraps back to origin
    window(8'h2A, 8'h00, 8'h00, 8'h00, 8'h01);
    window(8'h2B, 8'h00, 8'h00, 8'h00, 8'h01);
    send_cmd(8'h2C);
    send_pix(10'd0, 10'd0, 16'h1111);
    send_pix(10'd1, 10'd0, 16'h2222);
    send_pix(10'd0, 10'd1, 16'h3333);
    send_pix(10'd1, 10'd1, 16'h4444);
    send_pix(10'd0, 10'd0, 16'h5555);

    // 3: partial CASET must not commit
    send_cmd(8'h01);
    send_cmd(8'h2A);
    send_data(8'h00); send_data(8'h05);
    send_cmd(8'h2C);
    send_pix(10'd0, 10'd0, 16'hA5A5);
    send_pix(10'd1, 10'd0, 16'h5A5A);

    // rd low without a wr edge is not a bus error
    lcd_rd = 1'b0;
    repeat (6) @(negedge clk);
    lcd_rd = 1'b1;

    // 4: panel reset mid-pixel clears outputs and window, drops pending data
    window(8'h2A, 8'h00, 8'h03, 8'h00, 8'h05);
    window(8'h2B, 8'h00, 8'h02, 8'h00, 8'h02);
    send_cmd(8'h2C);
    send_pix(10'd3, 10'd2, 16'hABCD);
    send_data(8'h11);
    lcd_reset = 1'b0;
    repeat (4) @(negedge clk);
    check("lrst_pix_x", 32'(pix_x), 32'd0);
    check("lrst_pix_y", 32'(pix_y), 32'd0);
    check("lrst_pix_rgb", 32'(pix_rgb), 32'd0);
    check("lrst_cmd_code", 32'(cmd_code), 32'd0);
    lcd_reset = 1'b1;
    repeat (3) @(negedge clk);
    send_data(8'h22); send_data(8'h33); send_data(8'h44);
    send_cmd(8'h2C);
    send_pix(10'd0, 10'd0, 16'h5555);

    // 5: window crossing the right edge, RAMWRC continuation, unknown opcode
    window(8'h2A, 8'h01, 8'h3E, 8'h01, 8'h41);
    window(8'h2B, 8'h00, 8'h00, 8'h00, 8'h00);
    send_cmd(8'h2C);
    send_pix(10'd318, 10'd0, 16'h0102);
    send_pix(10'd319, 10'd0, 16'h0304);
    send_pix(10'd318, 10'd0, 16'h0506);
    send_cmd(8'h3C);
    send_pix(10'd319, 10'd0, 16'h0708);
    send_cmd(8'h36);
    send_data(8'h12); send_data(8'h34);

    // 6: bus error still decodes; command in RAM_LO drops the high byte
    send_cmd(8'h01);
    send_cmd(8'h2C);
    bus_write(1'b1, 8'h12, 1'b0, 1'b0, 10'd0, 10'd0, 16'd0);
    bus_write(1'b1, 8'h34, 1'b1, 1'b1, 10'd0, 10'd0, 16'h1234);
    send_data(8'hAB);
    send_cmd(8'h3C);
    send_pix(10'd1, 10'd0, 16'h5678);

    repeat (10) @(negedge clk);
    check("pix_queue_drained", 32'(pq.size()), 32'd0);
    check("cmd_queue_drained", 32'(cq.size()), 32'd0);
    check("err_queue_drained", 32'(eq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
